// File: rtl/sqrt_input_wrapper_p.sv
// sqrt_input_wrapper_p
// Input stage for the floating-point square-root unit. Captures one operand,
// resolves zero/negative/NaN/infinity locally, and for every other operand
// normalises denormals, forces an even exponent and hands the core an aligned
// radicand plus the half exponent with a single start pulse.
module sqrt_input_wrapper_p #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [EXP_W+MAN_W:0]   a_in,
  input  logic                   sqrt_done,
  output logic                   busy,
  output logic                   start_sqrt,
  output logic [MAN_W+1:0]       mant_out,
  output logic [EXP_W-1:0]       exp_out,
  output logic                   special_valid,
  output logic [EXP_W+MAN_W:0]   special_result
);

  localparam int OP_W = 1 + EXP_W + MAN_W;
  localparam int E_W  = EXP_W + 2;

  // Exponent arithmetic is done signed, two bits wider than the field, so the
  // deepest denormal (1-BIAS-MAN_W) still fits without wrapping.
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_BIAS = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_DEN  = E_ONE - E_BIAS;

  localparam logic [OP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NORM,
    S_ALIGN,
    S_START,
    S_WAIT,
    S_SPECIAL
  } state_t;

  state_t                  state_reg;
  logic [MAN_W:0]          m_reg;
  logic signed [E_W-1:0]   e_reg;

  // Operand field decode
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_frac;
  logic             exp_ones;
  logic             exp_zero;
  logic             frac_zero;
  logic             is_special;
  logic [OP_W-1:0]  special_sel;
  logic signed [E_W-1:0] e_adj;

  assign a_sign    = a_in[OP_W-1];
  assign a_exp     = a_in[OP_W-2 -: EXP_W];
  assign a_frac    = a_in[MAN_W-1:0];
  assign exp_ones  = &a_exp;
  assign exp_zero  = ~|a_exp;
  assign frac_zero = ~|a_frac;

  // Odd exponents are pulled down by one; the mantissa is shifted up to match.
  assign e_adj = e_reg[0] ? (e_reg - E_ONE) : e_reg;

  assign busy = (state_reg != S_IDLE);

  // Classify the operand presented during LOAD and pick the bypass result.
  // Priority matters: NaN beats sign, and signed zero must keep its sign.
  always_comb begin
    is_special  = 1'b0;
    special_sel = '0;
    if (exp_ones && !frac_zero) begin
      is_special  = 1'b1;
      special_sel = QNAN;
    end else if (exp_zero && frac_zero) begin
      is_special  = 1'b1;
      special_sel = a_in;
    end else if (a_sign) begin
      is_special  = 1'b1;
      special_sel = QNAN;
    end else if (exp_ones) begin
      is_special  = 1'b1;
      special_sel = a_in;
    end
  end

  // Sequencer: all outputs except busy are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      m_reg          <= '0;
      e_reg          <= '0;
      start_sqrt     <= 1'b0;
      mant_out       <= '0;
      exp_out        <= '0;
      special_valid  <= 1'b0;
      special_result <= '0;
    end else begin
      start_sqrt    <= 1'b0;
      special_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (run) state_reg <= S_LOAD;
        end
        S_LOAD: begin
          if (is_special) begin
            special_valid  <= 1'b1;
            special_result <= special_sel;
            state_reg      <= S_SPECIAL;
          end else if (exp_zero) begin
            m_reg     <= {1'b0, a_frac};
            e_reg     <= E_DEN;
            state_reg <= S_NORM;
          end else begin
            m_reg     <= {1'b1, a_frac};
            e_reg     <= $signed({2'b00, a_exp}) - E_BIAS;
            state_reg <= S_ALIGN;
          end
        end
        S_NORM: begin
          // Exit is decided on the pre-shift value, so the shift that brings
          // the leading one to the top is the last NORM cycle.
          m_reg <= {m_reg[MAN_W-1:0], 1'b0};
          e_reg <= e_reg - E_ONE;
          if (m_reg[MAN_W-1]) state_reg <= S_ALIGN;
        end
        S_ALIGN: begin
          mant_out   <= e_reg[0] ? {m_reg, 1'b0} : {1'b0, m_reg};
          exp_out    <= EXP_W'((e_adj >>> 1) + E_BIAS);
          e_reg      <= e_adj;
          start_sqrt <= 1'b1;
          state_reg  <= S_START;
        end
        S_START: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (sqrt_done) state_reg <= S_IDLE;
        end
        S_SPECIAL: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_input_wrapper_p.sv
// Testbench for sqrt_input_wrapper_p (default 8/23 single-precision layout).
// Expected results are queued when an operand is issued and popped when the
// DUT raises start_sqrt or special_valid.
module tb_sqrt_input_wrapper_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] a_in;
  logic        sqrt_done;
  logic        busy;
  logic        start_sqrt;
  logic [24:0] mant_out;
  logic [7:0]  exp_out;
  logic        special_valid;
  logic [31:0] special_result;

  sqrt_input_wrapper_p #(.EXP_W(8), .MAN_W(23)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .a_in           (a_in),
    .sqrt_done      (sqrt_done),
    .busy           (busy),
    .start_sqrt     (start_sqrt),
    .mant_out       (mant_out),
    .exp_out        (exp_out),
    .special_valid  (special_valid),
    .special_result (special_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_special;
    logic [31:0] result;
    logic [24:0] mant;
    logic [7:0]  expo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk_norm(input logic [24:0] mt, input logic [7:0] ex, input int lat);
    exp_t r;
    r.is_special = 1'b0; r.result = '0; r.mant = mt; r.expo = ex; r.lat = lat;
    return r;
  endfunction

  function automatic exp_t mk_spec(input logic [31:0] res);
    exp_t r;
    r.is_special = 1'b1; r.result = res; r.mant = '0; r.expo = '0; r.lat = 2;
    return r;
  endfunction

  // Reference: value-level view of the input stage for IEEE single precision.
  function automatic exp_t model(input logic [31:0] a);
    exp_t r;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [23:0] m;
    int e, k, p;
    ex = a[30:23];
    fr = a[22:0];
    if (ex == 8'hFF && fr != 0)      r = mk_spec(32'h7FC00000);
    else if (ex == 0 && fr == 0)     r = mk_spec(a);
    else if (a[31])                  r = mk_spec(32'h7FC00000);
    else if (ex == 8'hFF)            r = mk_spec(a);
    else begin
      if (ex == 0) begin
        p = 0;
        for (int i = 0; i < 23; i++) if (fr[i]) p = i;
        k = 23 - p;
        m = {1'b0, fr} << k;
        e = -126 - k;
      end else begin
        k = 0;
        m = {1'b1, fr};
        e = int'(ex) - 127;
      end
      r = mk_norm('0, '0, 3 + k);
      if (e % 2 != 0) begin
        r.mant = {m, 1'b0};
        e = e - 1;
      end else begin
        r.mant = {1'b0, m};
      end
      r.expo = 8'(e / 2 + 127);
    end
    return r;
  endfunction

  // Issue one operand with a single-cycle run pulse and check its outcome.
  task automatic run_op(input logic [31:0] a, input exp_t want);
    exp_t got;
    bit   found;
    int   lat;
    sb.push_back(want);
    @(negedge clk);
    a_in = a;
    run  = 1'b1;
    @(posedge clk);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (i == 1) begin
        run = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_load a=%08h got=%b want=1", a, busy); end
      end
      if (start_sqrt === 1'b1 || special_valid === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL timeout a=%08h no start_sqrt/special_valid within 40 cycles", a);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    got = sb.pop_front();
    checks++;
    if (special_valid !== got.is_special || start_sqrt !== !got.is_special) begin
      errors++;
      $display("FAIL kind a=%08h got special_valid=%b start_sqrt=%b want special=%b", a, special_valid, start_sqrt, got.is_special);
    end
    checks++;
    if (lat != got.lat) begin
      errors++;
      $display("FAIL latency a=%08h got=%0d want=%0d", a, lat, got.lat);
    end
    if (got.is_special) begin
      checks++;
      if (special_result !== got.result) begin
        errors++; $display("FAIL special_result a=%08h got=%08h want=%08h", a, special_result, got.result);
      end
      @(negedge clk);
      checks++;
      if (special_valid !== 1'b0 || busy !== 1'b0 || start_sqrt !== 1'b0) begin
        errors++; $display("FAIL idle_after_special a=%08h got sv=%b busy=%b start=%b want 0/0/0", a, special_valid, busy, start_sqrt);
      end
    end else begin
      checks++;
      if (mant_out !== got.mant || exp_out !== got.expo) begin
        errors++; $display("FAIL result a=%08h got mant=%07h exp=%02h want mant=%07h exp=%02h", a, mant_out, exp_out, got.mant, got.expo);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (start_sqrt !== 1'b0 || busy !== 1'b1 || mant_out !== got.mant || exp_out !== got.expo) begin
          errors++; $display("FAIL wait_hold a=%08h got start=%b busy=%b mant=%07h exp=%02h", a, start_sqrt, busy, mant_out, exp_out);
        end
      end
      sqrt_done = 1'b1;
      @(negedge clk);
      sqrt_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_drop a=%08h got=%b want=0", a, busy); end
    end
    $display("op a=%08h lat=%0d special=%b result=%08h mant=%07h exp=%02h", a, lat, got.is_special, special_result, mant_out, exp_out);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || start_sqrt !== 1'b0 || mant_out !== '0 || exp_out !== '0 ||
        special_valid !== 1'b0 || special_result !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b start=%b mant=%07h exp=%02h sv=%b sr=%08h want all 0",
               tag, busy, start_sqrt, mant_out, exp_out, special_valid, special_result);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; sqrt_done = 1'b0; a_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_normal;
    logic [31:0] a;
    run_op(32'h40800000, mk_norm(25'h0800000, 8'h80, 3));
    run_op(32'h40000000, mk_norm(25'h1000000, 8'h7F, 3));
    run_op(32'h3F800000, mk_norm(25'h0800000, 8'h7F, 3));
    for (int i = 0; i < 3; i++) begin
      a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(a, model(a));
    end
  endtask

  task automatic test_denormal;
    logic [31:0] a;
    run_op(32'h00000001, mk_norm(25'h1000000, 8'h34, 26));
    run_op(32'h00400000, model(32'h00400000));
    for (int i = 0; i < 2; i++) begin
      a = {9'b0, 23'($urandom_range(1, (1 << 23) - 1))};
      run_op(a, model(a));
    end
  endtask

  task automatic test_specials;
    run_op(32'hC0800000, mk_spec(32'h7FC00000));
    run_op(32'h80000000, mk_spec(32'h80000000));
    run_op(32'h7F800000, mk_spec(32'h7F800000));
    run_op(32'h7F800001, mk_spec(32'h7FC00000));
    run_op(32'hFF800000, mk_spec(32'h7FC00000));
    run_op(32'h00000000, mk_spec(32'h00000000));
  endtask

  // Abort an operation with reset after `delay` cycles, then run a clean one.
  task automatic test_reset_mid(input logic [31:0] a, input int delay, input string tag);
    int starts;
    @(negedge clk);
    a_in = a;
    run  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (delay - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_before got=%b want=1", tag, busy); end
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start_sqrt === 1'b1 || busy === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin errors++; $display("FAIL %s_no_activity got=%0d active cycles want 0", tag, starts); end
    $display("reset during %s: outputs cleared", tag);
    run_op(a, model(a));
  endtask

  task automatic test_ignored_inputs;
    bit found;
    found = 1'b0;
    @(negedge clk);
    a_in = 32'h40800000;
    run  = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (i == 1) run = 1'b0;
      if (start_sqrt === 1'b1) begin
        found = 1'b1;
        checks++;
        if (i != 3) begin errors++; $display("FAIL ign_latency got=%0d want=3", i); end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL ign_timeout no start_sqrt within 10 cycles");
      return;
    end
    sqrt_done = 1'b1;
    @(negedge clk);
    sqrt_done = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_in_start got busy=%b want=1", busy); end
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (start_sqrt !== 1'b0 || busy !== 1'b1 || mant_out !== 25'h0800000 || exp_out !== 8'h80) begin
        errors++;
        $display("FAIL run_in_wait got start=%b busy=%b mant=%07h exp=%02h want 0/1/0800000/80", start_sqrt, busy, mant_out, exp_out);
      end
    end
    run = 1'b0;
    sqrt_done = 1'b1;
    @(negedge clk);
    sqrt_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_drop got=%b want=0", busy); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (start_sqrt !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL ign_second_start got start=%b busy=%b want 0/0", start_sqrt, busy);
      end
    end
    $display("ignored run/sqrt_done: single operation completed");
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops [2];
    exp_t got;
    bit found;
    ops[0] = 32'h40800000;
    ops[1] = 32'h40000000;
    sb.push_back(model(ops[0]));
    sb.push_back(model(ops[1]));
    @(negedge clk);
    a_in = ops[0];
    run  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      found = 1'b0;
      for (int i = 1; i <= 10 && !found; i++) begin
        @(negedge clk);
        if (start_sqrt === 1'b1) begin
          found = 1'b1;
          if (n == 1) begin
            checks++;
            if (i != 3) begin errors++; $display("FAIL b2b_gap got=%0d want=3", i); end
          end
        end
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL b2b_timeout op=%0d", n);
        run = 1'b0;
        sb.delete();
        return;
      end
      got = sb.pop_front();
      checks++;
      if (mant_out !== got.mant || exp_out !== got.expo) begin
        errors++; $display("FAIL b2b_result op=%0d got mant=%07h exp=%02h want mant=%07h exp=%02h", n, mant_out, exp_out, got.mant, got.expo);
      end
      $display("b2b op=%0d a=%08h mant=%07h exp=%02h", n, ops[n], mant_out, exp_out);
      if (n == 1) run = 1'b0;
      @(negedge clk);
      sqrt_done = 1'b1;
      if (n == 0) a_in = ops[1];
      @(negedge clk);
      sqrt_done = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (start_sqrt !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL b2b_tail got start=%b busy=%b want 0/0", start_sqrt, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_denormal();
    test_specials();
    test_reset_mid(32'h40800000, 5, "mid_wait");
    test_reset_mid(32'h00000001, 6, "mid_norm");
    test_ignored_inputs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
